// File: rtl/lsu_bus_master_if.sv
// Shared peripheral/memory bus seen by the load/store unit.
// The LSU drives the request side (master); the memory or peripheral
// fabric answers with read data and a ready strobe (slave).
interface lsu_bus_master_if #(
    parameter int ADDR_W = 32
);
    logic              busReq;
    logic [ADDR_W-1:0] busAddr;
    logic [31:0]       busWData;
    logic              busWe;
    logic [3:0]        busStrb;
    logic [31:0]       busRData;
    logic              busReady;

    modport master (
        output busReq,
        output busAddr,
        output busWData,
        output busWe,
        output busStrb,
        input  busRData,
        input  busReady
    );

    modport slave (
        input  busReq,
        input  busAddr,
        input  busWData,
        input  busWe,
        input  busStrb,
        output busRData,
        output busReady
    );
endinterface

// File: rtl/lsu_bus_master.sv
// Load/store unit between the RV32I datapath and the shared bus.
// Accepts one request at a time, steers store data onto byte lanes,
// tolerates wait states with a bounded timeout, and returns extended
// load data or an error flag as a single-cycle response pulse.
module lsu_bus_master #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    lsu_bus_master_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        func3_q;
    logic [1:0]        off_q;
    logic              req_ready_q;
    logic              busy_q;
    logic              busReq_q;
    logic [ADDR_W-1:0] busAddr_q;
    logic [31:0]       busWData_q;
    logic              busWe_q;
    logic [3:0]        busStrb_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic              req_err_d;
    logic [31:0]       wdata_d;
    logic [3:0]        strb_d;
    logic [ADDR_W-1:0] addr_d;

    // Replicate the store operand across every lane it may land on.
    function automatic logic [31:0] steer_wdata(input logic [2:0] f3,
                                                input logic [31:0] wd);
        logic [31:0] r;
        case (f3[1:0])
            2'd0:    r = {4{wd[7:0]}};
            2'd1:    r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Byte enables: loads always read the full word.
    function automatic logic [3:0] steer_strb(input logic we,
                                              input logic [2:0] f3,
                                              input logic [1:0] off);
        logic [3:0] r;
        if (!we) begin
            r = 4'b1111;
        end else begin
            case (f3[1:0])
                2'd0:    r = 4'b0001 << off;
                2'd1:    r = 4'b0011 << off;
                default: r = 4'b1111;
            endcase
        end
        return r;
    endfunction

    // Pick the addressed byte/half out of the word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                                 input logic [1:0] off,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[8*off +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd4:    r = {24'd0, b};
            3'd5:    r = {16'd0, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    // Decode the incoming request: legality, alignment, lane steering.
    always_comb begin
        logic illegal;
        logic misalign;
        illegal   = req_we ? (req_func3 > 3'd2)
                           : (req_func3 == 3'd3 || req_func3 >= 3'd6);
        misalign  = (req_func3[1:0] == 2'd1 && req_addr[0]) ||
                    (req_func3[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
        req_err_d = illegal || misalign;
        wdata_d   = req_we ? steer_wdata(req_func3, req_wdata) : 32'd0;
        strb_d    = steer_strb(req_we, req_func3, req_addr[1:0]);
        addr_d    = {req_addr[ADDR_W-1:2], 2'b00};
    end

    // Control FSM with registered bus and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            func3_q     <= 3'd0;
            off_q       <= 2'd0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            busReq_q    <= 1'b0;
            busAddr_q   <= '0;
            busWData_q  <= 32'd0;
            busWe_q     <= 1'b0;
            busStrb_q   <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        func3_q     <= req_func3;
                        off_q       <= req_addr[1:0];
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (req_err_d) begin
                            // Rejected requests never reach the bus.
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'd0;
                        end else begin
                            state_q    <= ACCESS;
                            busReq_q   <= 1'b1;
                            busAddr_q  <= addr_d;
                            busWData_q <= wdata_d;
                            busWe_q    <= req_we;
                            busStrb_q  <= strb_d;
                        end
                    end
                end
                ACCESS: begin
                    // A ready in the last allowed cycle still wins over timeout.
                    if (bus.busReady || cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_q     <= RESP;
                        cnt_q       <= '0;
                        busReq_q    <= 1'b0;
                        busAddr_q   <= '0;
                        busWData_q  <= 32'd0;
                        busWe_q     <= 1'b0;
                        busStrb_q   <= 4'd0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= !bus.busReady;
                        rsp_rdata_q <= (bus.busReady && !busWe_q)
                                       ? load_extract(func3_q, off_q, bus.busRData)
                                       : 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'd0;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign busy         = busy_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign bus.busReq   = busReq_q;
    assign bus.busAddr  = busAddr_q;
    assign bus.busWData = busWData_q;
    assign bus.busWe    = busWe_q;
    assign bus.busStrb  = busStrb_q;

endmodule
